// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// WB control bit positions, FSM state type and the default abort budget.
package mem_pkg;

  localparam int WB_REGWRITE            = 1;
  localparam int WB_MEMTOREG            = 0;
  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  // A store or a load occupies the data-memory port; a store wins when both are set.
  function automatic logic is_access(input logic mem_write, input logic [1:0] wb);
    return mem_write | wb[WB_MEMTOREG];
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM-stage access unit (master)
// and the data memory (slave).
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ready, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ready, dmem_rdata
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts BUSY cycles spent waiting on the data memory; expired_o flags the
// last permitted wait cycle so the access unit can abort on that edge.
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear on BUSY entry, advance on each unanswered BUSY cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (inc_i) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = inc_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: two-state IDLE/BUSY handshake, pipeline
// stall and WB-stage register. Optional BUSY abort under MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          WB_mem,
  input  logic                M_mem,
  input  logic [31:0]         ALUResult_mem,
  input  logic [31:0]         MemWriteData_mem,
  input  logic [4:0]          rdAddr_mem,
  mem_access_unit_if.master   dmem,
  output logic                stall,
  output logic [1:0]          WB_wb,
  output logic [31:0]         rdData_wb,
  output logic [4:0]          rdAddr_wb,
  output logic                mem_err
);

  mem_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [1:0]  wb_lat_q, wb_lat_d;
  logic [4:0]  rd_lat_q, rd_lat_d;
  logic [1:0]  wb_wb_q, wb_wb_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        access_s;
  logic        busy_s;
  logic        wait_s;
  logic        timeout_s;
  logic        stall_s;

  assign access_s = is_access(M_mem, WB_mem);
  assign busy_s   = (state_q == ST_BUSY);
  assign wait_s   = busy_s && !dmem.dmem_ready;

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic err_q;

  mem_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .clr_i     ((state_q == ST_IDLE) && access_s),
    .inc_i     (wait_s),
    .expired_o (timeout_s)
  );

  // Sticky abort flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | timeout_s;
    end
  end

  assign mem_err = err_q;
`else
  logic [31:0] unused_timeout_s;

  assign unused_timeout_s = 32'(TIMEOUT_CYCLES);
  assign timeout_s        = 1'b0;
  assign mem_err          = 1'b0;
`endif

  // Next state, request latching and WB-stage update; stall cycles inject a bubble.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    wb_lat_d  = wb_lat_q;
    rd_lat_d  = rd_lat_q;
    wb_wb_d   = wb_wb_q;
    rd_data_d = rd_data_q;
    rd_addr_d = rd_addr_q;
    stall_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access_s) begin
          state_d  = ST_BUSY;
          addr_d   = ALUResult_mem;
          wdata_d  = MemWriteData_mem;
          we_d     = M_mem;
          wb_lat_d = WB_mem;
          rd_lat_d = rdAddr_mem;
          stall_s  = 1'b1;
          wb_wb_d  = 2'b00;
        end else begin
          wb_wb_d   = WB_mem;
          rd_data_d = ALUResult_mem;
          rd_addr_d = rdAddr_mem;
        end
      end
      ST_BUSY: begin
        if (dmem.dmem_ready) begin
          state_d   = ST_IDLE;
          wb_wb_d   = wb_lat_q;
          rd_addr_d = rd_lat_q;
          rd_data_d = we_q ? addr_q : dmem.dmem_rdata;
        end else if (timeout_s) begin
          state_d = ST_IDLE;
          wb_wb_d = 2'b00;
        end else begin
          stall_s = 1'b1;
          wb_wb_d = 2'b00;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wb_wb_d = 2'b00;
      end
    endcase
  end

  // State, request and WB-stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      we_q      <= 1'b0;
      wb_lat_q  <= 2'b00;
      rd_lat_q  <= 5'd0;
      wb_wb_q   <= 2'b00;
      rd_data_q <= 32'h0000_0000;
      rd_addr_q <= 5'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      wb_lat_q  <= wb_lat_d;
      rd_lat_q  <= rd_lat_d;
      wb_wb_q   <= wb_wb_d;
      rd_data_q <= rd_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  // Reset drops stall at once, even while the inputs still present an access.
  assign stall           = stall_s & ~rst;
  assign dmem.dmem_req   = busy_s;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign WB_wb           = wb_wb_q;
  assign rdData_wb       = rd_data_q;
  assign rdAddr_wb       = rd_addr_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum BUSY cycles before abort; used only with MEM_ACCESS_TIMEOUT_EN.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 WB_mem  in  2  from the EX/MEM register; [1]=RegWrite, [0]=MemtoReg (load).
REQ-006 M_mem  in  1  MemWrite (store).
REQ-007 ALUResult_mem  in  32  effective address, or the result for non-memory ops.
REQ-008 MemWriteData_mem  in  32  store data.
REQ-009 rdAddr_mem  in  5  destination register.
REQ-010 dmem_req  out  1  data-memory request valid.
REQ-011 dmem_we  out  1  1=write, 0=read.
REQ-012 dmem_addr  out  32  request address.
REQ-013 dmem_wdata  out  32  write data.
REQ-014 dmem_ready  in  1  memory accepts or completes the current request.
REQ-015 dmem_rdata  in  32  read data, valid when dmem_ready=1 on a read.
REQ-016 stall  out  1  hold EX/MEM and earlier stages.
REQ-017 WB_wb  out  2  registered WB controls to the WB stage.
REQ-018 rdData_wb  out  32  registered load data or ALU result.
REQ-019 rdAddr_wb  out  5  registered destination register.
REQ-020 mem_err  out  1  sticky timeout flag.

Function
REQ-021 A cycle is an access when M_mem=1 or WB_mem[0]=1. If both are set, it SHALL be treated as a store.
REQ-022 The FSM SHALL have two states. In IDLE, an access latches address, data and we into the dmem_* registers and moves to BUSY. In BUSY, dmem_ready=1 returns to IDLE.
REQ-023 dmem_req SHALL be 1 exactly while in BUSY. dmem_addr, dmem_wdata and dmem_we SHALL hold stable while dmem_req=1.
REQ-024 stall SHALL be combinational: (IDLE and access) or (BUSY and not dmem_ready).
REQ-025 A non-access in IDLE SHALL register WB_wb=WB_mem, rdData_wb=ALUResult_mem and rdAddr_wb=rdAddr_mem at the next edge, with 1-cycle latency.
REQ-026 On the BUSY edge where dmem_ready=1, the unit SHALL register the latched WB and rdAddr. rdData_wb SHALL be dmem_rdata for a load and the latched address for a store. Minimum access latency is 2 cycles.
REQ-027 On every edge where stall=1, WB_wb SHALL be loaded with 2'b00 (bubble); rdData_wb and rdAddr_wb hold.
REQ-028 In BUSY, the unit SHALL ignore changes on the *_mem inputs.
REQ-029 dmem_ready while in IDLE SHALL be ignored.

Reset
REQ-030 On rst=1, the unit SHALL immediately enter IDLE and clear dmem_req, dmem_we, dmem_addr, dmem_wdata, WB_wb, rdData_wb, rdAddr_wb and mem_err to 0.
REQ-031 Reset during BUSY SHALL abandon the transaction with no writeback.

Configuration
REQ-032 Macro MEM_ACCESS_TIMEOUT_EN defined: a counter SHALL clear on entry to BUSY and increment each BUSY cycle without dmem_ready.
REQ-033 With the macro defined, when the count reaches TIMEOUT_CYCLES, the unit SHALL drop dmem_req, return to IDLE, deassert stall that cycle, emit a bubble, and set mem_err until reset.
REQ-034 Macro MEM_ACCESS_TIMEOUT_EN undefined: BUSY SHALL wait indefinitely, and mem_err SHALL be constant 0.

Structure
REQ-035 Shared package mem_pkg SHALL hold the WB bit-index constants (WB_REGWRITE=1, WB_MEMTOREG=0), the FSM state typedef and the TIMEOUT_CYCLES default.
REQ-036 One sub-module, mem_timeout_ctr, SHALL implement the counter and be instantiated only under MEM_ACCESS_TIMEOUT_EN.

Verification
REQ-037 Non-access: WB_mem=2'b10, ALUResult=0x00000005, rd=3 -> next cycle WB_wb=2'b10, rdData_wb=0x5, rdAddr_wb=3; stall never 1.
REQ-038 Load: WB_mem=2'b11, addr=0x100, dmem_ready after 2 BUSY cycles, rdata=0xDEADBEEF -> stall high 3 cycles, dmem_addr=0x100, dmem_we=0, then WB_wb=2'b11, rdData_wb=0xDEADBEEF.
REQ-039 Store: M_mem=1, addr=0x200, wdata=0x12345678, immediate ready -> dmem_we=1 for one BUSY cycle, stall 1 cycle, WB_wb=2'b00.
REQ-040 Input change in BUSY: toggle ALUResult_mem to 0x999 during wait -> dmem_addr stays 0x100.
REQ-041 Reset mid-BUSY: assert rst with dmem_req=1 -> dmem_req=0, stall=0 and WB_wb=0 immediately, without waiting for clk.
REQ-042 With MEM_ACCESS_TIMEOUT_EN and TIMEOUT_CYCLES=4, never assert ready -> req drops after 4 BUSY cycles, mem_err=1 and stays 1, WB_wb=2'b00.
